// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: latency limit, FSM state
// encodings, write-lane masks and the sub-word alignment rule used when
// DMEM_ALIGN_CHECK_EN is defined.
package dmem_responder_pkg;

    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [0:0] DMEM_IDLE = 1'b0;
    localparam logic [0:0] DMEM_WAIT = 1'b1;

    // Big-endian lanes: bit 3 is byte offset 0 (wdata[31:24]).
    localparam logic [3:0] WEN_WORD    = 4'b1111;
    localparam logic [3:0] WEN_HALF_HI = 4'b1100;
    localparam logic [3:0] WEN_HALF_LO = 4'b0011;
    localparam logic [3:0] WEN_BYTE0   = 4'b1000;
    localparam logic [3:0] WEN_BYTE1   = 4'b0100;
    localparam logic [3:0] WEN_BYTE2   = 4'b0010;
    localparam logic [3:0] WEN_BYTE3   = 4'b0001;

    // A write is naturally aligned when its lane mask matches the byte offset.
    function automatic logic wen_aligned(input logic [3:0] wen, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (wen)
            WEN_WORD:    ok = (off == 2'b00);
            WEN_HALF_HI: ok = (off == 2'b00);
            WEN_HALF_LO: ok = (off == 2'b10);
            WEN_BYTE0:   ok = (off == 2'b00);
            WEN_BYTE1:   ok = (off == 2'b01);
            WEN_BYTE2:   ok = (off == 2'b10);
            WEN_BYTE3:   ok = (off == 2'b11);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_bank.sv
// dmem_bank: four byte-wide lane arrays with per-lane synchronous write and
// combinational read. Lane 3 holds byte offset 0 (the most significant byte).
module dmem_bank #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [7:0] lane_mem [4][DEPTH];

    // Per-lane byte write on the rising edge.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < 4; l++) begin
            if (we[l]) begin
                lane_mem[l][waddr] <= wdata[8*l +: 8];
            end
        end
    end

    // Assemble the whole word from the four lanes.
    always_comb begin
        rdata = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            rdata[8*l +: 8] = lane_mem[l][raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-SRAM port. Applies byte-lane
// writes immediately and returns whole read words after LAT cycles, raising
// busy while a multi-cycle read is outstanding.
// Optional macro DMEM_ALIGN_CHECK_EN: suppress misaligned writes and pulse err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_data_ok,
    output logic        data_sram_busy,
    output logic        data_sram_err
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    ridx_q, ridx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;

    logic [AW-1:0]    word_idx;
    logic             is_write;
    logic             lanes_legal;
    logic [3:0]       bank_we;
    logic [AW-1:0]    bank_raddr;
    logic [31:0]      bank_rdata;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{data_sram_addr[31:AW+2], data_sram_addr[1:0]};

    // Request decode: word index, direction and lane legality.
    always_comb begin
        word_idx = data_sram_addr[AW+1:2];
        is_write = (data_sram_wen != 4'b0000);
`ifdef DMEM_ALIGN_CHECK_EN
        lanes_legal = wen_aligned(data_sram_wen, data_sram_addr[1:0]);
`else
        lanes_legal = 1'b1;
`endif
    end

    dmem_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (word_idx),
        .wdata (data_sram_wdata),
        .raddr (bank_raddr),
        .rdata (bank_rdata)
    );

    // Next-state: accept in IDLE, count down in WAIT, sample the array on completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ridx_d     = ridx_q;
        rdata_d    = rdata_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        bank_we    = '0;
        bank_raddr = word_idx;
        case (state_q)
            DMEM_IDLE: begin
                if (data_sram_en) begin
                    if (is_write) begin
                        ok_d = 1'b1;
                        if (lanes_legal) begin
                            bank_we = data_sram_wen;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (LAT == 1) begin
                        rdata_d = bank_rdata;
                        ok_d    = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = CNT_W'(LAT - 1);
                        ridx_d  = word_idx;
                    end
                end
            end
            default: begin
                // No writes are accepted while waiting, so reading at the
                // final edge sees the same word as at acceptance.
                bank_raddr = ridx_q;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DMEM_IDLE;
                    rdata_d = bank_rdata;
                    ok_d    = 1'b1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset; a pending read is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            ridx_q  <= '0;
            rdata_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ridx_q  <= ridx_d;
            rdata_q <= rdata_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign data_sram_rdata   = rdata_q;
    assign data_sram_data_ok = ok_q;
    assign data_sram_busy    = (state_q == DMEM_WAIT);
    assign data_sram_err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LAT=1 instance and one LAT=4 instance, a
// cycle-level behavioural model of each, a per-cycle compare process and
// directed literal checks.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, ok0, busy0, err0;
    logic [3:0]  wen0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        rst1, en1, ok1, busy1, err1;
    logic [3:0]  wen1;
    logic [31:0] addr1, wdata1, rdata1;

    dmem_responder #(.DEPTH(1024), .AW(10), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst0), .data_sram_en(en0), .data_sram_wen(wen0),
        .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
        .data_sram_data_ok(ok0), .data_sram_busy(busy0), .data_sram_err(err0)
    );

    dmem_responder #(.DEPTH(1024), .AW(10), .LAT(4)) u_lat4 (
        .clk(clk), .rst(rst1), .data_sram_en(en1), .data_sram_wen(wen1),
        .data_sram_addr(addr1), .data_sram_wdata(wdata1), .data_sram_rdata(rdata1),
        .data_sram_data_ok(ok1), .data_sram_busy(busy1), .data_sram_err(err1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    // Model state, indexed by instance (0: LAT=1, 1: LAT=4). Times are cycle numbers.
    logic [31:0] mm [2][1024];
    int          t [2];
    int          done_c [2];
    int          busy_until [2];
    bit          pend [2];
    logic [31:0] pdata [2];
    logic [31:0] e_rd [2];
    bit          e_ok [2];
    bit          e_busy [2];
    bit          e_err [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bit legal(input logic [3:0] w, input logic [1:0] o);
`ifdef DMEM_ALIGN_CHECK_EN
        case ({w, o})
            6'b1111_00, 6'b1100_00, 6'b0011_10,
            6'b1000_00, 6'b0100_01, 6'b0010_10, 6'b0001_11: return 1'b1;
            default: return 1'b0;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    // One clock edge of the model: decide acceptance from the busy window,
    // apply writes to the word array and schedule completions by cycle number.
    task automatic model_step(input int k, input int L, input logic r, input logic e,
                              input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        int cur;
        bit nok, nerr;
        int wi;
        logic [31:0] word;
        cur = t[k];
        wi  = int'(a[11:2]);
        if (r) begin
            pend[k] = 1'b0; busy_until[k] = -1;
            e_ok[k] = 1'b0; e_err[k] = 1'b0; e_busy[k] = 1'b0; e_rd[k] = 32'h0;
        end else begin
            nok = 1'b0; nerr = 1'b0;
            if (pend[k] && done_c[k] == cur + 1) begin
                nok = 1'b1; e_rd[k] = pdata[k]; pend[k] = 1'b0;
            end
            if (e && cur > busy_until[k]) begin
                if (w != 4'b0000) begin
                    nok = 1'b1;
                    if (legal(w, a[1:0])) begin
                        word = mm[k][wi];
                        for (int b = 0; b < 4; b++)
                            if (w[b]) word[8*b +: 8] = d[8*b +: 8];
                        mm[k][wi] = word;
                    end else begin
                        nerr = 1'b1;
                    end
                end else if (L == 1) begin
                    nok = 1'b1; e_rd[k] = mm[k][wi];
                end else begin
                    pend[k] = 1'b1; done_c[k] = cur + L; pdata[k] = mm[k][wi];
                    busy_until[k] = cur + L - 1;
                end
            end
            e_ok[k]   = nok;
            e_err[k]  = nerr;
            e_busy[k] = (cur + 1 <= busy_until[k]);
        end
        t[k] = cur + 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0, 1, rst0, en0, wen0, addr0, wdata0);
        model_step(1, 4, rst1, en1, wen1, addr1, wdata1);
    end

    // Compare every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("cmp0_ok",    ok0,    e_ok[0]);
            check("cmp0_busy",  busy0,  e_busy[0]);
            check("cmp0_err",   err0,   e_err[0]);
            check("cmp0_rdata", rdata0, e_rd[0]);
            check("cmp1_ok",    ok1,    e_ok[1]);
            check("cmp1_busy",  busy1,  e_busy[1]);
            check("cmp1_err",   err1,   e_err[1]);
            check("cmp1_rdata", rdata1, e_rd[1]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic drv0(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en0 = e; wen0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drv1(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en1 = e; wen1 = w; addr1 = a; wdata1 = d;
    endtask

    logic [31:0] exp_align_word;
    logic        exp_align_err;

    initial begin
        for (int k = 0; k < 2; k++) begin
            t[k] = 0; done_c[k] = 0; busy_until[k] = -1; pend[k] = 1'b0;
            pdata[k] = '0; e_rd[k] = '0; e_ok[k] = 1'b0; e_busy[k] = 1'b0; e_err[k] = 1'b0;
            for (int i = 0; i < 1024; i++) mm[k][i] = '0;
        end
        rst0 = 1'b1; rst1 = 1'b1;
        drv0(1'b0, 4'h0, 32'h0, 32'h0);
        drv1(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_ok0",    ok0,    1'b0);
        check("rst_busy0",  busy0,  1'b0);
        check("rst_err0",   err0,   1'b0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_busy1",  busy1,  1'b0);
        rst0 = 1'b0; rst1 = 1'b0; armed = 1'b1;
        @(negedge clk);

        // LAT=1: word write then read in the next cycle
        drv0(1'b1, 4'b1111, 32'h10, 32'h11223344);
        @(negedge clk);
        check("wr_ok", ok0, 1'b1);
        drv0(1'b1, 4'b0000, 32'h10, 32'h0);
        @(negedge clk);
        check("rd_word", rdata0, 32'h11223344);
        check("rd_ok", ok0, 1'b1);
        check("rd_busy", busy0, 1'b0);

        // byte write at offset 1
        drv0(1'b1, 4'b0100, 32'h11, 32'hAAAAAAAA);
        @(negedge clk);
        check("bw_rdata_hold", rdata0, 32'h11223344);
        drv0(1'b1, 4'b0000, 32'h10, 32'h0);
        @(negedge clk);
        check("rd_byte", rdata0, 32'h11AA3344);

        // low half write over a zero word
        drv0(1'b1, 4'b1111, 32'h20, 32'h0);
        @(negedge clk);
        drv0(1'b1, 4'b0011, 32'h22, 32'hBEEFBEEF);
        @(negedge clk);
        drv0(1'b1, 4'b0000, 32'h20, 32'h0);
        @(negedge clk);
        check("rd_half", rdata0, 32'h0000BEEF);

        // back-to-back reads, then address wrap modulo DEPTH*4
        drv0(1'b1, 4'b0000, 32'h13, 32'h0);
        @(negedge clk);
        check("b2b_rd0", rdata0, 32'h11AA3344);
        drv0(1'b1, 4'b1111, 32'h1010, 32'h55667788);
        @(negedge clk);
        drv0(1'b1, 4'b0000, 32'h10, 32'h0);
        @(negedge clk);
        check("wrap_rd", rdata0, 32'h55667788);
        drv0(1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        check("idle_ok", ok0, 1'b0);

        // misaligned half write at offset 2 with the high-half mask
`ifdef DMEM_ALIGN_CHECK_EN
        exp_align_word = 32'h01020304; exp_align_err = 1'b1;
`else
        exp_align_word = 32'hA5A50304; exp_align_err = 1'b0;
`endif
        drv0(1'b1, 4'b1111, 32'h0, 32'h01020304);
        @(negedge clk);
        drv0(1'b1, 4'b1100, 32'h02, 32'hA5A5A5A5);
        @(negedge clk);
        check("align_err", err0, exp_align_err);
        check("align_ok", ok0, 1'b1);
        drv0(1'b1, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        check("align_word", rdata0, exp_align_word);
        check("align_rd_err", err0, 1'b0);
        drv0(1'b0, 4'b0000, 32'h0, 32'h0);

        // LAT=4: writes complete in one cycle, reads hold busy for three
        drv1(1'b1, 4'b1111, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        check("l4_wr_ok", ok1, 1'b1);
        drv1(1'b1, 4'b1111, 32'h44, 32'h0BADBEEF);
        @(negedge clk);
        check("l4_wr_busy", busy1, 1'b0);
        drv1(1'b1, 4'b0000, 32'h40, 32'h0);            // cycle c
        @(negedge clk);                                // c+1
        check("l4_busy_c1", busy1, 1'b1);
        drv1(1'b1, 4'b0000, 32'h44, 32'h0);            // second request held
        @(negedge clk);                                // c+2
        check("l4_busy_c2", busy1, 1'b1);
        check("l4_ok_c2", ok1, 1'b0);
        @(negedge clk);                                // c+3
        check("l4_busy_c3", busy1, 1'b1);
        @(negedge clk);                                // c+4
        check("l4_busy_c4", busy1, 1'b0);
        check("l4_ok_c4", ok1, 1'b1);
        check("l4_rd1", rdata1, 32'hCAFEF00D);
        @(negedge clk);                                // c+5: second accepted at c+4
        drv1(1'b0, 4'b0000, 32'h0, 32'h0);
        check("l4_busy_c5", busy1, 1'b1);
        check("l4_hold_c5", rdata1, 32'hCAFEF00D);
        repeat (3) @(negedge clk);                     // c+8
        check("l4_ok_c8", ok1, 1'b1);
        check("l4_rd2", rdata1, 32'h0BADBEEF);
        @(negedge clk);

        // LAT=4: reset two cycles into a pending read
        drv1(1'b1, 4'b0000, 32'h40, 32'h0);            // cycle c
        @(negedge clk);
        drv1(1'b0, 4'b0000, 32'h0, 32'h0);
        check("rst_mid_busy", busy1, 1'b1);
        @(negedge clk);                                // c+2
        rst1 = 1'b1;
        @(negedge clk);                                // c+3
        check("rst_mid_busy0", busy1, 1'b0);
        check("rst_mid_rdata", rdata1, 32'h0);
        rst1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rst_mid_no_ok", ok1, 1'b0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (memory) end of the CPU data-SRAM port; the load/store unit in the M stage is the initiator.
- Holds a word array, applies byte-lane writes and returns whole 32-bit read words after a configurable latency.
- The initiator does all sub-word extraction; this block never shifts or sign-extends.
- Used as the simulation/FPGA data memory behind the core, optionally with wait states to exercise pipeline stall paths.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of 2.
- AW, 10: word-index width; must equal log2(DEPTH).
- LAT, 1: read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- data_sram_en  in  1  request valid.
- data_sram_wen  in  4  byte write enables; 4'b0000 means read.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data, already lane-replicated by the initiator.
- data_sram_rdata  out  32  read word, registered.
- data_sram_data_ok  out  1  one-cycle completion pulse.
- data_sram_busy  out  1  responder cannot accept a request this cycle.
- data_sram_err  out  1  misaligned-enable error pulse (optional feature only).

Behaviour:
- Reset values: rdata=0, data_ok=0, busy=0, err=0, state=IDLE, latency counter=0. Array contents are not reset.
- Reset asserted mid-read: the pending read is dropped and no data_ok is produced.
- Acceptance: a request is accepted on the edge where en=1 and busy=0. When busy=1, en is ignored and the initiator holds its request.
- Word index: addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- addr[1:0] is ignored for data selection.
- Byte lanes are big-endian, matching the load/store unit:
  - wen[3] writes wdata[31:24] (offset 0)
  - wen[2] writes wdata[23:16] (offset 1)
  - wen[1] writes wdata[15:8] (offset 2)
  - wen[0] writes wdata[7:0] (offset 3)
- Write (wen!=0):
  - Enabled lanes are updated on the acceptance edge.
  - data_ok=1 for exactly the next cycle.
  - rdata holds its previous value.
  - busy never asserts for writes.
- Read (wen==0), request presented in cycle c:
  - LAT=1: rdata = mem[idx] and data_ok=1 in cycle c+1. busy stays 0, so back-to-back reads are allowed every cycle.
  - LAT>1: state goes IDLE->WAIT and the counter loads LAT-1. busy=1 in cycles c+1 .. c+LAT-1. The counter decrements each cycle. On the edge where it reaches 0, the array is read, state returns to IDLE, and rdata/data_ok appear in cycle c+LAT.
  - rdata holds until the next read completes.
- Read-after-write to the same word in consecutive cycles returns the updated bytes. The write commits before the read samples.
- A new request may be accepted in the same cycle data_ok is high (pipelined completion).
- FSM states: IDLE, WAIT only.
  - IDLE: accepts any request.
  - WAIT: no acceptance; leaves when the counter reaches 0.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined, a write is legal only if wen is one of:
  - 1111 with addr[1:0]=00
  - 1100 with addr[1:0]=00, or 0011 with addr[1:0]=10
  - a single lane matching addr[1:0] (1000/00, 0100/01, 0010/10, 0001/11)
- Any other nonzero wen/offset pair:
  - the write is suppressed (array unchanged);
  - err=1 in the next cycle, together with data_ok=1.
- Reads are never flagged.
- When not defined: err is tied to 0 and every write is applied exactly per wen.

Decomposition:
- defines.vh gains the LAT limit constant, the FSM state encodings (DMEM_IDLE, DMEM_WAIT) and the lane masks (WEN_WORD, WEN_HALF_HI, WEN_HALF_LO, WEN_BYTE0..3).
- Sub-module dmem_bank:
  - four 8-bit-wide DEPTH-entry lane arrays;
  - per-lane write enable;
  - synchronous write, combinational read;
  - instantiated once.
- The top level holds the FSM, the counter, the output registers and the alignment check.

Test Plan:
- LAT=1: write addr 0x10 wen=1111 wdata=0x11223344, then read 0x10 in the next cycle -> rdata=0x11223344 with data_ok one cycle after the read request; busy stays 0.
- Byte write addr 0x11 wen=0100 wdata=0xAAAAAAAA over word 0x11223344, then read 0x10 -> 0x11AA3344.
- Half write addr 0x22 wen=0011 wdata=0xBEEFBEEF over word 0x00000000, then read 0x20 -> 0x0000BEEF.
- LAT=4: read presented in cycle 5 -> busy=1 in cycles 6-8; a second request held high in cycle 6 is accepted only in cycle 9; data_ok for the first read is in cycle 9.
- LAT=4: assert rst in cycle 7 of a pending read -> no data_ok ever appears; busy=0 and rdata=0 from cycle 8.
- DMEM_ALIGN_CHECK_EN: write wen=1100 at addr 0x02 -> err=1 and data_ok=1 in the next cycle; a subsequent read of 0x00 shows the word unchanged. Without the macro, the same write updates bytes 0-1 and err stays 0.
